if_fetch: RTL and testbench
===========================

Name: if_fetch

Overview:
- Instruction-fetch unit. It is the consumer end of the PC register's `pc_o`/`pc_reg_rdy` handshake and drives `pc_reg_stall` back to it.
- Fetches one 32-bit instruction per accepted PC over the byte-wide RAM read port, using a small direct-mapped instruction cache.
- Hands {pc, instruction} to decode under a valid/stall handshake.
- Discards in-flight work on a branch flush.

Parameters:
ADDR_W, 32, address/PC width
IDX_W, 6, icache index bits (2^IDX_W one-word lines; tag = pc[ADDR_W-1:IDX_W+2])

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global ready; 0 freezes the block
pc_i  in  ADDR_W  PC from PC register
pc_valid_i  in  1  PC valid this cycle
pc_reg_stall  out  1  hold PC register
flush_i  in  1  branch taken; abandon current fetch
id_stall_i  in  1  decode cannot accept
mem_a  out  ADDR_W  RAM byte address
mem_rd_en  out  1  RAM read request this cycle
mem_din  in  8  RAM byte; valid the cycle after the address is issued
inst_valid_o  out  1  instruction output valid
inst_o  out  32  fetched instruction, little-endian
inst_pc_o  out  ADDR_W  PC of inst_o

Behaviour:
- Reset: `rst` is synchronous, active-high; clock is `clk`.
  - All outputs reset to 0; state = IDLE.
  - All cache valid bits cleared.
  - Reset mid-fetch aborts the fetch; no cache fill occurs.
- `pc_reg_stall` (combinational) = (state != IDLE) || (inst_valid_o && id_stall_i).
- Accept condition: IDLE && `pc_valid_i` && !`pc_reg_stall` && `rdy` && !`flush_i`. On accept, latch `pc_i` into `cur_pc`.
- Cache hit (valid[idx] && tag match):
  - `inst_valid_o`=1 the next cycle, with `inst_o`=line and `inst_pc_o`=`cur_pc`.
  - Latency 1 cycle; state stays IDLE.
- Cache miss: go to FETCH.
  - `issue_cnt` (0..4) and `cap_cnt` (0..4) start at 0.
  - Each FETCH cycle with `rdy`=1 and `issue_cnt`<4: `mem_rd_en`=1, `mem_a`=`cur_pc`+`issue_cnt` (wraps mod 2^ADDR_W); increment `issue_cnt`.
  - A byte is captured when the previous cycle issued: `mem_din` goes into byte lane `cap_cnt`, then `cap_cnt`++.
  - When `cap_cnt` reaches 4:
    - Write the cache line with tag, set valid.
    - Present `inst_o`/`inst_pc_o`, set `inst_valid_o`=1.
    - Return to IDLE.
  - Miss latency: accept in cycle N -> addresses in N+1..N+4, bytes in N+2..N+5 -> `inst_valid_o` in N+6.
- `rdy`=0:
  - All registers hold and `mem_rd_en`=0.
  - A byte issued in the cycle before `rdy` fell is still captured.
  - No byte is lost or duplicated; `issue_cnt` is never more than `cap_cnt`+1.
- Output hold: while `inst_valid_o` && `id_stall_i`, `inst_o`/`inst_pc_o`/`inst_valid_o` hold. When `id_stall_i`=0, `inst_valid_o` drops the next cycle unless a new instruction is produced.
- `flush_i`=1 (highest priority after `rst`):
  - Next cycle: state=IDLE, `inst_valid_o`=0, counters cleared.
  - No cache fill for the aborted fetch; partial bytes are discarded.
  - A PC presented in the same cycle as `flush_i` is not accepted.
- Simultaneous completion and `flush_i`: flush wins; the instruction is not output and not cached.
- Address alignment: no alignment check; an unaligned PC is fetched byte-wise as given. A cache hit requires a matching full tag; pc[1:0] is excluded from tag and index.

Test Plan:
1. Reset, RAM[0..3]=13 05 10 00, `pc_i`=0 valid at cycle 1 -> `mem_a` 0,1,2,3 in cycles 2-5; `inst_o`=0x00100513, `inst_pc_o`=0, `inst_valid_o` in cycle 7; `pc_reg_stall`=1 in cycles 2-6.
2. Refetch PC 0 after test 1 -> no `mem_rd_en`; `inst_o`=0x00100513 valid one cycle after accept.
3. PC 0x4 miss; `rdy`=0 for 2 cycles after the second address issue -> exactly 4 reads at 4,5,6,7; correct word; completion delayed by 2 cycles.
4. PC 0x8 miss; `flush_i` pulsed in the third FETCH cycle -> IDLE next cycle, `inst_valid_o` never asserted; later fetch of 0x8 misses again (not cached).
5. Hit with `id_stall_i`=1 for 3 cycles -> `inst_o`/`inst_pc_o` held stable, `pc_reg_stall`=1, next `pc_i` accepted only after `id_stall_i` drops.
6. PCs 0x0 and 0x100 (same index, IDX_W=6) -> second access misses and evicts; re-access of 0x0 misses and refetches 4 bytes.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction-fetch unit: accepts a PC, looks it up in a direct-mapped
// one-word-per-line icache and, on a miss, assembles the instruction from
// four byte reads of the RAM port before handing {pc, inst} to decode.
module if_fetch #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned IDX_W  = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_reg_stall,
    input  logic              flush_i,
    input  logic              id_stall_i,
    output logic [ADDR_W-1:0] mem_a,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_din,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o
);

    localparam int unsigned LINES = 1 << IDX_W;
    localparam int unsigned TAG_W = ADDR_W - IDX_W - 2;

    typedef enum logic {IDLE, FETCH} state_t;

    state_t              state;
    logic [ADDR_W-1:0]   cur_pc;
    logic [2:0]          issue_cnt;
    logic [2:0]          cap_cnt;
    logic                issued_q;
    logic [23:0]         fill_buf;
    logic [LINES-1:0]    line_valid;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [IDX_W-1:0]    pc_idx;
    logic [TAG_W-1:0]    pc_tag;
    logic [IDX_W-1:0]    cur_idx;
    logic [TAG_W-1:0]    cur_tag;
    logic                hit;
    logic                accept;
    logic                fill_done;
    logic [31:0]         fill_word;

    // Tag/index split, hit detection, handshake and RAM request decode
    always_comb begin
        pc_idx       = pc_i[IDX_W+1:2];
        pc_tag       = pc_i[ADDR_W-1:IDX_W+2];
        cur_idx      = cur_pc[IDX_W+1:2];
        cur_tag      = cur_pc[ADDR_W-1:IDX_W+2];
        hit          = line_valid[pc_idx] && (tag_mem[pc_idx] == pc_tag);
        pc_reg_stall = (state != IDLE) || (inst_valid_o && id_stall_i);
        accept       = (state == IDLE) && pc_valid_i && !pc_reg_stall && rdy && !flush_i;
        mem_rd_en    = (state == FETCH) && rdy && (issue_cnt < 3'd4);
        mem_a        = cur_pc + ADDR_W'(issue_cnt);
        fill_done    = (state == FETCH) && issued_q && (cap_cnt == 3'd3) && !flush_i;
        fill_word    = {mem_din, fill_buf};
    end

    // Fetch FSM, byte capture, output register and line-valid bits
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cur_pc       <= '0;
            issue_cnt    <= '0;
            cap_cnt      <= '0;
            issued_q     <= 1'b0;
            fill_buf     <= '0;
            line_valid   <= '0;
            inst_valid_o <= 1'b0;
            inst_o       <= '0;
            inst_pc_o    <= '0;
        end else if (flush_i) begin
            state        <= IDLE;
            issue_cnt    <= '0;
            cap_cnt      <= '0;
            issued_q     <= 1'b0;
            inst_valid_o <= 1'b0;
        end else if (state == FETCH) begin
            // a byte requested last cycle lands now, even if rdy has just fallen
            issued_q <= mem_rd_en;
            if (mem_rd_en) begin
                issue_cnt <= issue_cnt + 3'd1;
            end
            if (fill_done) begin
                line_valid[cur_idx] <= 1'b1;
                inst_o              <= fill_word;
                inst_pc_o           <= cur_pc;
                inst_valid_o        <= 1'b1;
                state               <= IDLE;
                issue_cnt           <= '0;
                cap_cnt             <= '0;
            end else if (issued_q) begin
                fill_buf[{cap_cnt[1:0], 3'b000} +: 8] <= mem_din;
                cap_cnt <= cap_cnt + 3'd1;
            end
        end else if (rdy) begin
            if (accept) begin
                cur_pc <= pc_i;
                if (hit) begin
                    inst_o       <= data_mem[pc_idx];
                    inst_pc_o    <= pc_i;
                    inst_valid_o <= 1'b1;
                end else begin
                    state        <= FETCH;
                    issue_cnt    <= '0;
                    cap_cnt      <= '0;
                    inst_valid_o <= 1'b0;
                end
            end else if (!id_stall_i) begin
                inst_valid_o <= 1'b0;
            end
        end
    end

    // Cache line payload; only meaningful where line_valid is set
    always_ff @(posedge clk) begin
        if (fill_done && !rst) begin
            tag_mem[cur_idx]  <= cur_tag;
            data_mem[cur_idx] <= fill_word;
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: byte RAM model plus a reference icache
// model (index/tag/word per line) predicting hit/miss, word and latency.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic [31:0] pc_i;
    logic        pc_valid_i;
    logic        pc_reg_stall;
    logic        flush_i;
    logic        id_stall_i;
    logic [31:0] mem_a;
    logic        mem_rd_en;
    logic [7:0]  mem_din;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0]  ram     [1024];
    logic        m_valid [64];
    logic [23:0] m_tag   [64];
    logic [31:0] m_data  [64];
    logic [31:0] pool    [8];

    if_fetch #(.ADDR_W(32), .IDX_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .pc_i(pc_i), .pc_valid_i(pc_valid_i),
        .pc_reg_stall(pc_reg_stall), .flush_i(flush_i), .id_stall_i(id_stall_i),
        .mem_a(mem_a), .mem_rd_en(mem_rd_en), .mem_din(mem_din),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o)
    );

    always #5 clk = ~clk;

    // RAM answers one cycle after the address
    always @(posedge clk) mem_din <= ram[mem_a[9:0]];

    function automatic logic [31:0] ram_word(input logic [31:0] pc);
        logic [31:0] a0, a1, a2, a3;
        a0 = pc; a1 = pc + 32'd1; a2 = pc + 32'd2; a3 = pc + 32'd3;
        return {ram[a3[9:0]], ram[a2[9:0]], ram[a1[9:0]], ram[a0[9:0]]};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 64; i++) m_valid[i] = 1'b0;
    endtask

    // One fetch; rdy is low for gap_len cycles starting gap_at cycles after accept
    task automatic run_fetch(input logic [31:0] pc, input int gap_at, input int gap_len);
        logic [5:0]  idx;
        logic        exp_hit;
        logic [31:0] exp_word;
        int          exp_lat, iss, lat, nreads;
        idx      = pc[7:2];
        exp_hit  = m_valid[idx] && (m_tag[idx] == pc[31:8]);
        exp_word = exp_hit ? m_data[idx] : ram_word(pc);
        exp_lat  = 1;
        if (!exp_hit) begin
            iss = 0;
            for (int k = 1; k < 40; k++) begin
                if (!(gap_len > 0 && k >= gap_at && k < gap_at + gap_len)) iss++;
                if (iss == 4) begin exp_lat = k + 2; break; end
            end
        end
        pc_i = pc; pc_valid_i = 1'b1; rdy = 1'b1; flush_i = 1'b0; id_stall_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc_reg_stall !== 1'b0) $display("FAIL accept_ready pc=%h stall=%b want 0", pc, pc_reg_stall);
        else n_pass++;
        next_cycle();
        pc_valid_i = 1'b0; pc_i = $urandom;
        lat = 0; nreads = 0;
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            rdy = !(gap_len > 0 && k >= gap_at && k < gap_at + gap_len);
            @(negedge clk);
            if (mem_rd_en) begin
                n_checks++;
                if (mem_a !== pc + 32'(nreads))
                    $display("FAIL mem_addr pc=%h got %h want %h", pc, mem_a, pc + 32'(nreads));
                else n_pass++;
                nreads++;
            end
            if (inst_valid_o) lat = k;
            else if (!exp_hit) begin
                n_checks++;
                if (pc_reg_stall !== 1'b1) $display("FAIL busy_stall pc=%h k=%0d got %b want 1", pc, k, pc_reg_stall);
                else n_pass++;
            end
            if (lat == 0) next_cycle();
        end
        n_checks++;
        if (lat != exp_lat) $display("FAIL latency pc=%h got %0d want %0d", pc, lat, exp_lat);
        else n_pass++;
        n_checks++;
        if (nreads != (exp_hit ? 0 : 4)) $display("FAIL read_count pc=%h got %0d want %0d", pc, nreads, exp_hit ? 0 : 4);
        else n_pass++;
        n_checks++;
        if (inst_o !== exp_word) $display("FAIL inst pc=%h got %h want %h", pc, inst_o, exp_word);
        else n_pass++;
        n_checks++;
        if (inst_pc_o !== pc) $display("FAIL inst_pc got %h want %h", inst_pc_o, pc);
        else n_pass++;
        next_cycle();
        rdy = 1'b1;
        if (!exp_hit) begin
            m_valid[idx] = 1'b1; m_tag[idx] = pc[31:8]; m_data[idx] = exp_word;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; pc_i = '0; pc_valid_i = 1'b0; flush_i = 1'b0; id_stall_i = 1'b0;
        next_cycle(); next_cycle();
        @(negedge clk);
        n_checks++;
        if ({inst_valid_o, inst_o, inst_pc_o, mem_rd_en, pc_reg_stall} !== 67'd0)
            $display("FAIL reset_outputs got v=%b i=%h p=%h rd=%b st=%b want all 0",
                     inst_valid_o, inst_o, inst_pc_o, mem_rd_en, pc_reg_stall);
        else n_pass++;
        next_cycle();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_miss_basic();
        run_fetch(32'h0, 0, 0);
        n_checks++;
        if (inst_o !== 32'h00100513) $display("FAIL first_word got %h want 00100513", inst_o);
        else n_pass++;
    endtask

    task automatic test_hit();
        run_fetch(32'h0, 0, 0);
    endtask

    task automatic test_rdy_gap();
        run_fetch(32'h4, 3, 2);
    endtask

    task automatic test_flush();
        int seen;
        seen = 0;
        pc_i = 32'h8; pc_valid_i = 1'b1; rdy = 1'b1; flush_i = 1'b0;
        next_cycle();
        pc_valid_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            flush_i = (k == 3);
            @(negedge clk);
            if (inst_valid_o) seen++;
            if (k == 4) begin
                n_checks++;
                if ({pc_reg_stall, mem_rd_en} !== 2'b00)
                    $display("FAIL flush_idle got stall=%b rd=%b want 0 0", pc_reg_stall, mem_rd_en);
                else n_pass++;
            end
            next_cycle();
        end
        flush_i = 1'b0;
        n_checks++;
        if (seen != 0) $display("FAIL flush_no_valid got %0d valid cycles want 0", seen);
        else n_pass++;
        run_fetch(32'h8, 0, 0);
        // a PC offered together with flush must be ignored
        pc_i = 32'h0; pc_valid_i = 1'b1; flush_i = 1'b1;
        next_cycle();
        pc_valid_i = 1'b0; flush_i = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if ({inst_valid_o, mem_rd_en} !== 2'b00)
                $display("FAIL flush_blocks_accept got v=%b rd=%b want 0 0", inst_valid_o, mem_rd_en);
            else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_id_stall();
        logic [31:0] w0, w4;
        w0 = m_data[0]; w4 = m_data[1];
        pc_i = 32'h0; pc_valid_i = 1'b1; rdy = 1'b1; id_stall_i = 1'b0;
        next_cycle();
        pc_i = 32'h4; id_stall_i = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({inst_valid_o, pc_reg_stall, inst_o, inst_pc_o} !== {2'b11, w0, 32'h0})
                $display("FAIL stall_hold k=%0d got v=%b st=%b i=%h p=%h want 1 1 %h 0",
                         k, inst_valid_o, pc_reg_stall, inst_o, inst_pc_o, w0);
            else n_pass++;
            next_cycle();
        end
        id_stall_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pc_reg_stall !== 1'b0) $display("FAIL stall_release got %b want 0", pc_reg_stall);
        else n_pass++;
        next_cycle();
        pc_valid_i = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, w4, 32'h4})
            $display("FAIL after_stall got v=%b i=%h p=%h want 1 %h 4", inst_valid_o, inst_o, inst_pc_o, w4);
        else n_pass++;
        next_cycle();
    endtask

    task automatic test_evict();
        run_fetch(32'h100, 0, 0);
        run_fetch(32'h0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) pool[i] = 32'($urandom_range(0, 1023));
        for (int i = 0; i < 40; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 1023)) : pool[$urandom_range(0, 7)];
            run_fetch(pc, int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_reset_midfetch();
        pc_i = 32'h200; pc_valid_i = 1'b1; rdy = 1'b1;
        next_cycle();
        pc_valid_i = 1'b0;
        next_cycle(); next_cycle(); next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        n_checks++;
        if ({inst_valid_o, pc_reg_stall} !== 2'b00)
            $display("FAIL reset_abort got v=%b st=%b want 0 0", inst_valid_o, pc_reg_stall);
        else n_pass++;
        next_cycle();
        run_fetch(32'h200, 0, 0);
        run_fetch(32'h0, 0, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) ram[i] = 8'($urandom);
        ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'h10; ram[3] = 8'h00;
        model_clear();
        test_reset();
        test_miss_basic();
        test_hit();
        test_rdy_gap();
        test_flush();
        test_id_stall();
        test_evict();
        test_random();
        test_reset_midfetch();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
